// File: rtl/memory_access_responder_pkg.sv
// Shared definitions for the memory access responder: default region sizes,
// FSM state encoding and the region decode / access-permission check.
package memory_access_responder_pkg;

  localparam int unsigned MAR_ADDR_W       = 14;
  localparam int unsigned MAR_DATA_W       = 32;
  localparam int unsigned MAR_CODE_SIZE    = 4096;
  localparam int unsigned MAR_PSTACK_SIZE  = 2048;
  localparam int unsigned MAR_USTACK_SIZE  = 2048;
  localparam int unsigned MAR_DATA_BASE    = 8192;
  localparam int unsigned MAR_FAULT_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } mar_state_t;

  typedef enum logic [1:0] {
    RGN_CODE   = 2'd0,
    RGN_PSTACK = 2'd1,
    RGN_USTACK = 2'd2,
    RGN_DATA   = 2'd3
  } mar_region_t;

  // Bounds are exclusive upper limits; any gap between the user stack and the
  // data base (only possible with inconsistent parameters) decodes as data.
  function automatic mar_region_t mar_decode_region(
    input int unsigned addr,
    input int unsigned code_end,
    input int unsigned pstack_end,
    input int unsigned ustack_end,
    input int unsigned data_base
  );
    mar_region_t rgn;
    if (addr < code_end) begin
      rgn = RGN_CODE;
    end else if (addr < pstack_end) begin
      rgn = RGN_PSTACK;
    end else if (addr < ustack_end) begin
      rgn = RGN_USTACK;
    end else if (addr >= data_base) begin
      rgn = RGN_DATA;
    end else begin
      rgn = RGN_DATA;
    end
    return rgn;
  endfunction

  function automatic logic mar_access_faults(
    input mar_region_t rgn,
    input logic        write,
    input logic        priv
  );
    logic fault;
    case (rgn)
      RGN_CODE:   fault = write;
      RGN_PSTACK: fault = !priv;
      default:    fault = 1'b0;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM; the read register only updates on an enabled
// read, so the last read word is held while the RAM is idle.
module single_port_ram #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned LP_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:LP_DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_access_responder.sv
// Region-checked request/response front end for a single-port RAM, with a
// sticky fault address and a saturating fault counter.
//
// state      | meaning
// IDLE       | ready for a request; permission checked on the handshake
// ACCESS     | RAM enabled for one cycle with the latched operation
// RESPOND    | response held until rsp_ready
module memory_access_responder
  import memory_access_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH            = MAR_ADDR_W,
  parameter int unsigned DATA_WIDTH            = MAR_DATA_W,
  parameter int unsigned CODE_AREA_SIZE        = MAR_CODE_SIZE,
  parameter int unsigned PRIVILEGED_STACK_SIZE = MAR_PSTACK_SIZE,
  parameter int unsigned USER_STACK_SIZE       = MAR_USTACK_SIZE,
  parameter int unsigned DATA_AREA_SIZE        = MAR_DATA_BASE,
  parameter int unsigned FAULT_COUNT_WIDTH     = MAR_FAULT_CNT_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_WIDTH-1:0]        req_address,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  input  logic                         privilege_mode_flag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_fault,
  output logic [ADDR_WIDTH-1:0]        fault_address,
  output logic [FAULT_COUNT_WIDTH-1:0] fault_count
);

  localparam int unsigned LP_CODE_END   = CODE_AREA_SIZE;
  localparam int unsigned LP_PSTACK_END = CODE_AREA_SIZE + PRIVILEGED_STACK_SIZE;
  localparam int unsigned LP_USTACK_END = LP_PSTACK_END + USER_STACK_SIZE;
  localparam int unsigned LP_DATA_BASE  = DATA_AREA_SIZE;
  localparam logic [FAULT_COUNT_WIDTH-1:0] LP_FAULT_MAX = '1;

  mar_state_t r_state;
  mar_state_t w_state_next;

  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [DATA_WIDTH-1:0]        r_wdata;
  logic                         r_write;
  logic                         r_priv;
  logic [ADDR_WIDTH-1:0]        r_fault_address;
  logic [FAULT_COUNT_WIDTH-1:0] r_fault_count;

  logic                  w_handshake;
  mar_region_t           w_req_region;
  logic                  w_req_fault;
  mar_region_t           w_lat_region;
  logic                  w_lat_fault;
  logic                  w_ram_en;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // Incoming request is judged live so a fault can skip ACCESS entirely.
  assign w_req_region = mar_decode_region(32'(req_address), LP_CODE_END,
                                          LP_PSTACK_END, LP_USTACK_END, LP_DATA_BASE);
  assign w_req_fault  = mar_access_faults(w_req_region, req_write, privilege_mode_flag);

  // Re-derived from the latched fields so rsp_fault cannot move under backpressure.
  assign w_lat_region = mar_decode_region(32'(r_addr), LP_CODE_END,
                                          LP_PSTACK_END, LP_USTACK_END, LP_DATA_BASE);
  assign w_lat_fault  = mar_access_faults(w_lat_region, r_write, r_priv);

  assign req_ready   = (r_state == ST_IDLE) && reset;
  assign w_handshake = req_valid && req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ram_en     = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_handshake) begin
          w_state_next = w_req_fault ? ST_RESPOND : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_ram_en     = 1'b1;
        w_state_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_priv  <= 1'b0;
    end else if (w_handshake) begin
      r_addr  <= req_address;
      r_wdata <= req_wdata;
      r_write <= req_write;
      r_priv  <= privilege_mode_flag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fault_address <= '0;
      r_fault_count   <= '0;
    end else if (w_handshake && w_req_fault) begin
      r_fault_address <= req_address;
      if (r_fault_count != LP_FAULT_MAX) begin
        r_fault_count <= r_fault_count + 1'b1;
      end
    end
  end

  assign fault_address = r_fault_address;
  assign fault_count   = r_fault_count;
  assign rsp_fault     = rsp_valid && w_lat_fault;
  assign rsp_rdata     = (rsp_valid && !r_write && !w_lat_fault) ? w_ram_rdata : '0;

  single_port_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clock (clock),
    .i_en    (w_ram_en),
    .i_we    (r_write),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_memory_access_responder.sv
// Scoreboard bench for memory_access_responder: expected responses are queued
// at request acceptance and compared when the response handshake occurs.
module tb_memory_access_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [13:0] req_address = '0;
  logic [31:0] req_wdata = '0;
  logic        privilege_mode_flag = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [13:0] fault_address;
  logic [7:0]  fault_count;

  typedef struct {
    logic        fault;
    logic        chk_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  memory_access_responder dut (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_address         (req_address),
    .req_wdata           (req_wdata),
    .privilege_mode_flag (privilege_mode_flag),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_rdata           (rsp_rdata),
    .rsp_fault           (rsp_fault),
    .fault_address       (fault_address),
    .fault_count         (fault_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Response monitor: inputs only change just after a rising edge, so the
  // values seen here are the ones the next rising edge will use.
  always @(negedge clock) begin
    exp_t e;
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_stale_rsp: got response fault=%0b rdata=%h, want no response", rsp_fault, rsp_rdata);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (rsp_fault !== e.fault)
          $display("FAIL sb_rsp_fault: got %0b want %0b", rsp_fault, e.fault);
        else
          n_pass++;
        if (e.chk_data) begin
          n_checks++;
          if (rsp_rdata !== e.rdata)
            $display("FAIL sb_rsp_rdata: got %h want %h", rsp_rdata, e.rdata);
          else
            n_pass++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one request and returns at the first sample showing rsp_valid.
  task automatic do_req(input logic wr, input logic [13:0] addr, input logic [31:0] wd,
                        input logic priv, input logic exp_fault, input logic chk,
                        input logic [31:0] exp_rdata, input int exp_lat, input string name);
    int   budget;
    int   lat;
    exp_t e;
    req_valid = 1'b1;
    req_write = wr;
    req_address = addr;
    req_wdata = wd;
    privilege_mode_flag = priv;
    budget = 0;
    while (!req_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL %s_accept: req_ready=0 after %0d cycles, want 1", name, budget);
      req_valid = 1'b0;
      return;
    end
    e.fault = exp_fault;
    e.chk_data = chk;
    e.rdata = exp_rdata;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    n_checks++;
    if (!rsp_valid || lat != exp_lat)
      $display("FAIL %s_latency: got %0d cycles (rsp_valid=%0b) want %0d", name, lat, rsp_valid, exp_lat);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %0b want 0", req_ready); else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); else n_pass++;
    n_checks++;
    if (rsp_fault !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL reset_rsp: got fault=%0b rdata=%h want 0/0", rsp_fault, rsp_rdata);
    else n_pass++;
    n_checks++;
    if (fault_address !== 14'd0 || fault_count !== 8'd0)
      $display("FAIL reset_fault_regs: got addr=%0d count=%0d want 0/0", fault_address, fault_count);
    else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_priv_stack();
    do_req(1'b1, 14'd4096, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h0, 2, "pstack_wr_priv");
    do_req(1'b0, 14'd4096, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 2, "pstack_rd_priv");
    do_req(1'b1, 14'd6144, 32'h0BADF00D, 1'b0, 1'b0, 1'b1, 32'h0, 2, "ustack_wr_user");
    do_req(1'b0, 14'd6144, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D, 2, "ustack_rd_user");
    n_checks++;
    if (fault_count !== 8'd0) $display("FAIL no_fault_count: got %0d want 0", fault_count); else n_pass++;
    tick();
  endtask

  task automatic test_user_fault();
    do_req(1'b0, 14'd5000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1, "pstack_rd_user");
    n_checks++;
    if (fault_address !== 14'd5000) $display("FAIL user_fault_addr: got %0d want 5000", fault_address); else n_pass++;
    n_checks++;
    if (fault_count !== 8'd1) $display("FAIL user_fault_count: got %0d want 1", fault_count); else n_pass++;
    tick();
  endtask

  task automatic test_code_region();
    logic [31:0] v0;
    // Code is never writable, so its content is whatever it was out of power-up.
    do_req(1'b0, 14'd100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2, "code_rd_user");
    v0 = rsp_rdata;
    do_req(1'b1, 14'd100, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h0, 1, "code_wr_priv");
    do_req(1'b1, 14'd100, 32'h12345678, 1'b0, 1'b1, 1'b1, 32'h0, 1, "code_wr_user");
    do_req(1'b0, 14'd100, 32'h0, 1'b1, 1'b0, 1'b1, v0, 2, "code_rd_priv");
    n_checks++;
    if (fault_count !== 8'd3 || fault_address !== 14'd100)
      $display("FAIL code_fault_regs: got count=%0d addr=%0d want 3/100", fault_count, fault_address);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    do_req(1'b1, 14'd8192, 32'hA5A50001, 1'b0, 1'b0, 1'b1, 32'h0, 2, "data_wr");
    tick();
    rsp_ready = 1'b0;
    do_req(1'b0, 14'd8192, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A50001, 2, "data_rd_bp");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A50001 || req_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got valid=%0b rdata=%h ready=%0b want 1/a5a50001/0",
                 i, rsp_valid, rsp_rdata, req_ready);
      else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL bp_release: got ready=%0b valid=%0b want 1/0", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic set_b2b(input int k);
    req_write = 1'b0;
    case (k)
      0: begin req_address = 14'd8192; privilege_mode_flag = 1'b0; end
      1: begin req_address = 14'd6144; privilege_mode_flag = 1'b0; end
      default: begin req_address = 14'd4096; privilege_mode_flag = 1'b1; end
    endcase
  endtask

  task automatic test_back_to_back();
    int   acc[3];
    int   k;
    int   budget;
    exp_t e;
    k = 0;
    budget = 0;
    set_b2b(0);
    req_valid = 1'b1;
    while (k < 3 && budget < 40) begin
      if (req_ready) begin
        e.fault = 1'b0;
        e.chk_data = 1'b1;
        e.rdata = (k == 0) ? 32'hA5A50001 : (k == 1) ? 32'h0BADF00D : 32'hDEADBEEF;
        sb.push_back(e);
        acc[k] = cyc;
        k++;
        tick();
        if (k < 3) set_b2b(k);
      end else begin
        tick();
      end
      budget++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (k != 3) begin
      $display("FAIL b2b_accepts: got %0d accepted want 3", k);
    end else begin
      n_pass++;
      n_checks++;
      if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3)
        $display("FAIL b2b_spacing: got %0d,%0d cycles want 3,3", acc[1] - acc[0], acc[2] - acc[1]);
      else n_pass++;
    end
    repeat (3) tick();
  endtask

  task automatic test_fault_saturation();
    logic [13:0] a;
    logic [13:0] last_a;
    last_a = '0;
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) begin
        a = 14'(200 + i);
        do_req(1'b1, a, 32'hFFFF0000, (i % 4 == 0), 1'b1, 1'b1, 32'h0, 1, "sat_code_wr");
      end else begin
        a = 14'(4096 + i);
        do_req(1'b0, a, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1, "sat_pstack_rd");
      end
      last_a = a;
      if (i == 9) begin
        n_checks++;
        if (fault_count !== 8'd13) $display("FAIL sat_partial_count: got %0d want 13", fault_count); else n_pass++;
      end
    end
    n_checks++;
    if (fault_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", fault_count); else n_pass++;
    n_checks++;
    if (fault_address !== last_a) $display("FAIL sat_addr: got %0d want %0d", fault_address, last_a); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_op();
    int   budget;
    logic seen;
    exp_t e;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_address = 14'd6144;
    req_wdata = 32'h11112222;
    privilege_mode_flag = 1'b0;
    budget = 0;
    while (!req_ready && budget < 50) begin
      tick();
      budget++;
    end
    tick();
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL rst_access: got valid=%0b ready=%0b want 0/0", rsp_valid, req_ready);
    else n_pass++;
    n_checks++;
    if (fault_count !== 8'd0 || fault_address !== 14'd0)
      $display("FAIL rst_fault_regs: got count=%0d addr=%0d want 0/0", fault_count, fault_address);
    else n_pass++;
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", req_ready); else n_pass++;
    seen = 1'b0;
    repeat (4) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL rst_stale_rsp: got rsp_valid=1 after reset want 0"); else n_pass++;
    rsp_ready = 1'b0;
    do_req(1'b1, 14'd6144, 32'h600D600D, 1'b0, 1'b0, 1'b1, 32'h0, 2, "ustack_wr_rst");
    e = sb.pop_back();
    reset = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_fault !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL rst_respond: got valid=%0b fault=%0b rdata=%h want 0/0/0", rsp_valid, rsp_fault, rsp_rdata);
    else n_pass++;
    tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    tick();
    do_req(1'b0, 14'd6144, 32'h0, 1'b0, 1'b0, 1'b1, 32'h600D600D, 2, "ustack_rd_after_rst");
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_priv_stack();
    test_user_fault();
    test_code_region();
    test_backpressure();
    test_back_to_back();
    test_fault_saturation();
    test_reset_mid_op();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
